// File: rtl/prim_pad_in_filter_pkg.sv
// Shared types and constants for the pad input filter and its synchronizer.
package prim_pad_in_filter_pkg;

    localparam int SyncStages = 2;

    typedef enum logic [0:0] {
        STABLE  = 1'b0,
        QUALIFY = 1'b1
    } filt_state_e;

endpackage

// File: rtl/prim_pad_in_sync.sv
// Multi-flop synchronizer for asynchronous pad inputs; depth comes from SyncStages.
module prim_pad_in_sync
    import prim_pad_in_filter_pkg::*;
#(
    parameter int unsigned     Width    = 1,
    parameter logic [Width-1:0] ResetVal = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] stages [SyncStages];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < SyncStages; i++) begin
                stages[i] <= ResetVal;
            end
        end else begin
            stages[0] <= d_i;
            for (int i = 1; i < SyncStages; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign q_o = stages[SyncStages-1];

endmodule

// File: rtl/prim_pad_in_filter.sv
// Pad input conditioner: synchronizer, runtime-programmable debounce filter, optional edge pulses.
// Edge pulses are built only when PRIM_PAD_IN_FILTER_EDGE_EN is defined.
//
// state   | meaning
// STABLE  | filtered level matches synchronized input, counter idle
// QUALIFY | candidate level differs, counting consecutive differing samples
module prim_pad_in_filter
    import prim_pad_in_filter_pkg::*;
#(
    parameter int unsigned CntWidth = 4,
    parameter logic        ResetVal = 1'b0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                in_i,
    input  logic                en_i,
    input  logic [CntWidth-1:0] thr_i,
    output logic                in_o,
    output logic                busy_o,
    output logic                rise_o,
    output logic                fall_o
);

    logic                sync;
    filt_state_e         state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                level_q, level_d;

    prim_pad_in_sync #(
        .Width    (1),
        .ResetVal (ResetVal)
    ) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (in_i),
        .q_o   (sync)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= STABLE;
            cnt_q   <= '0;
            level_q <= ResetVal;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    // thr_i is compared live, so lowering it below cnt accepts on the next edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        case (state_q)
            STABLE: begin
                cnt_d = '0;
                if (sync != level_q) begin
                    if (!en_i || (thr_i == '0)) begin
                        level_d = sync;
                    end else begin
                        state_d = QUALIFY;
                        cnt_d   = CntWidth'(1);
                    end
                end
            end
            QUALIFY: begin
                if (!en_i) begin
                    level_d = sync;
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (sync == level_q) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q >= thr_i) begin
                    level_d = sync;
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        busy_o = (state_q == QUALIFY);
        in_o   = level_q;
    end

`ifdef PRIM_PAD_IN_FILTER_EDGE_EN
    logic rise_q, fall_q;

    // Registered alongside level_q so the pulse coincides with the new in_o value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= level_d & ~level_q;
            fall_q <= ~level_d & level_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;
`else
    assign rise_o = 1'b0;
    assign fall_o = 1'b0;
`endif

endmodule

// File: tb/tb_prim_pad_in_filter.sv
// Directed bench for prim_pad_in_filter: per-cycle vector table plus hand-written corner sequences.
module tb_prim_pad_in_filter;

`ifdef PRIM_PAD_IN_FILTER_EDGE_EN
    localparam logic EdgeOn = 1'b1;
`else
    localparam logic EdgeOn = 1'b0;
`endif

    typedef struct {
        logic       in_v;
        logic       en_v;
        logic [3:0] thr_v;
        logic       lvl;
        logic       busy;
        logic       rise;
        logic       fall;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_raw = 1'b0;
    logic       en = 1'b1;
    logic [3:0] thr = 4'd0;
    logic       lvl, busy, rise, fall;

    int n_cmp = 0;
    int n_err = 0;
    vec_t vecs[$];

    prim_pad_in_filter #(
        .CntWidth (4),
        .ResetVal (1'b0)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .in_i   (in_raw),
        .en_i   (en),
        .thr_i  (thr),
        .in_o   (lvl),
        .busy_o (busy),
        .rise_o (rise),
        .fall_o (fall)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic e_lvl, input logic e_busy,
                             input logic e_rise, input logic e_fall);
        check({tag, ".in_o"},   lvl,  e_lvl);
        check({tag, ".busy_o"}, busy, e_busy);
        check({tag, ".rise_o"}, rise, e_rise & EdgeOn);
        check({tag, ".fall_o"}, fall, e_fall & EdgeOn);
    endtask

    task automatic add(input logic i, input logic e, input logic [3:0] t,
                       input logic l, input logic b, input logic r, input logic f);
        vec_t v;
        v.in_v = i; v.en_v = e; v.thr_v = t;
        v.lvl = l; v.busy = b; v.rise = r; v.fall = f;
        vecs.push_back(v);
    endtask

    initial begin
        // 3-cycle glitch with thr=3: suppressed, busy for 3 cycles
        add(1,1,3, 0,0,0,0); add(1,1,3, 0,0,0,0); add(1,1,3, 0,1,0,0);
        add(0,1,3, 0,1,0,0); add(0,1,3, 0,1,0,0); add(0,1,3, 0,0,0,0);
        add(0,1,3, 0,0,0,0);
        // step 0->1 with thr=3: accepted 6 cycles after the step
        add(1,1,3, 0,0,0,0); add(1,1,3, 0,0,0,0); add(1,1,3, 0,1,0,0);
        add(1,1,3, 0,1,0,0); add(1,1,3, 0,1,0,0); add(1,1,3, 1,0,1,0);
        add(1,1,3, 1,0,0,0);
        // thr=0 passes after synchronizer + 1
        add(0,1,0, 1,0,0,0); add(0,1,0, 1,0,0,0); add(0,1,0, 0,0,0,1);
        add(0,1,0, 0,0,0,0);
        // bypass with en=0 regardless of thr
        add(1,0,3, 0,0,0,0); add(1,0,3, 0,0,0,0); add(1,0,3, 1,0,1,0);
        add(0,0,3, 1,0,0,0); add(0,0,3, 1,0,0,0); add(0,0,3, 0,0,0,1);
        // 4-cycle pulse with thr=3: exactly long enough, then the fall is qualified too
        add(1,1,3, 0,0,0,0); add(1,1,3, 0,0,0,0); add(1,1,3, 0,1,0,0);
        add(1,1,3, 0,1,0,0); add(0,1,3, 0,1,0,0); add(0,1,3, 1,0,1,0);
        add(0,1,3, 1,1,0,0); add(0,1,3, 1,1,0,0); add(0,1,3, 1,1,0,0);
        add(0,1,3, 0,0,0,1); add(0,1,3, 0,0,0,0);

        // Reset with in_i=1, thr=0: in_o rises on cycle 3 after release
        rst = 1'b1; in_raw = 1'b1; en = 1'b1; thr = 4'd0;
        tick(); tick();
        check_all("rst_hold", 0, 0, 0, 0);
        rst = 1'b0;
        tick(); check_all("post_rst_c1", 0, 0, 0, 0);
        tick(); check_all("post_rst_c2", 0, 0, 0, 0);
        tick(); check_all("post_rst_c3", 1, 0, 1, 0);
        tick(); check_all("post_rst_c4", 1, 0, 0, 0);

        // Reset mid-QUALIFY: aborts, in_o back to ResetVal with no fall pulse
        thr = 4'd3; in_raw = 1'b0;
        tick(); tick(); tick();
        check_all("pre_abort", 1, 1, 0, 0);
        rst = 1'b1;
        tick(); check_all("rst_abort", 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        tick(); check_all("rst_abort_rel", 0, 0, 0, 0);

        foreach (vecs[k]) begin
            in_raw = vecs[k].in_v;
            en     = vecs[k].en_v;
            thr    = vecs[k].thr_v;
            tick();
            check_all($sformatf("vec%0d", k), vecs[k].lvl, vecs[k].busy,
                      vecs[k].rise, vecs[k].fall);
        end

        // thr lowered from 15 to 2 while cnt=5: accepted on the next edge
        en = 1'b1; thr = 4'd15; in_raw = 1'b1;
        repeat (7) tick();
        check_all("thr15_cnt5", 0, 1, 0, 0);
        thr = 4'd2;
        tick(); check_all("thr_drop", 1, 0, 1, 0);

        // en deasserted mid-QUALIFY: in_o takes sync on the next edge
        thr = 4'd15; in_raw = 1'b0;
        repeat (5) tick();
        check_all("en_pre", 1, 1, 0, 0);
        en = 1'b0;
        tick(); check_all("en_drop", 0, 0, 0, 1);
        tick(); check_all("en_drop_after", 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
